// File: rtl/gtb_pkg.sv
// gtb_pkg
// Shared definitions for the Gray burst generator and its neighbours
// (the gtbtg converter and the benches).
//   gtb_state_e   : controller state encoding (IDLE, RUN, DONE)
//   bin_to_gray() : binary -> reflected Gray code
//   gray_to_bin() : reflected Gray code -> binary
// The helpers operate on GTB_FN_W bits. Callers zero-extend narrower values
// on the way in and truncate on the way out; both conversions stay exact
// because the zero upper bits do not disturb the low bits.
package gtb_pkg;

  localparam int GTB_FN_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gtb_state_e;

  function automatic logic [GTB_FN_W-1:0] bin_to_gray(input logic [GTB_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running from the MSB downwards.
  function automatic logic [GTB_FN_W-1:0] gray_to_bin(input logic [GTB_FN_W-1:0] g);
    logic [GTB_FN_W-1:0] b;
    b[GTB_FN_W-1] = g[GTB_FN_W-1];
    for (int i = GTB_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_burst_ctrl.sv
// gray_burst_ctrl
// Burst sequencing FSM for gray_burst_gen: tracks the state, the
// remaining-beat counter and the latched direction, and produces the
// registered stream/status flags.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : burst request (accepted only in IDLE)
//   dir_i           : direction to latch at start (1 = up)
//   burst_len_i     : beat count to latch at start (0 = 2^N)
//   out_ready_i     : consumer ready
//   idle_o          : state is IDLE (datapath may load / capture a start)
//   handshake_o     : current beat is being accepted this cycle
//   dir_o           : latched direction for the datapath stepper
//   out_valid_o     : registered valid
//   last_o          : registered last-beat flag
//   busy_o          : registered, high whenever state is not IDLE
//   done_o          : registered one-cycle pulse after the final beat
module gray_burst_ctrl
  import gtb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         dir_i,
  input  logic [N-1:0] burst_len_i,
  input  logic         out_ready_i,
  output logic         idle_o,
  output logic         handshake_o,
  output logic         dir_o,
  output logic         out_valid_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o
);

  // remaining needs N+1 bits so a zero length can stand for a full 2^N burst.
  localparam logic [N:0] FULL_BURST = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE_BEAT   = (N+1)'(1);
  localparam logic [N:0] TWO_BEATS  = (N+1)'(2);

  gtb_state_e  state_q;
  logic [N:0]  remaining_q;
  logic        dir_q;
  logic        out_valid_q;
  logic        last_q;
  logic        busy_q;
  logic        done_q;

  logic        handshake;

  assign handshake   = out_valid_q & out_ready_i;

  assign idle_o      = (state_q == IDLE);
  assign handshake_o = handshake;
  assign dir_o       = dir_q;
  assign out_valid_o = out_valid_q;
  assign last_o      = last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b1;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q     <= RUN;
            dir_q       <= dir_i;
            remaining_q <= (burst_len_i == '0) ? FULL_BURST : {1'b0, burst_len_i};
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            // The first beat is registered now, so its last flag is too.
            last_q      <= (burst_len_i == N'(1));
          end
        end

        RUN: begin
          // Without a handshake every register holds, keeping the beat stable.
          if (handshake) begin
            remaining_q <= remaining_q - ONE_BEAT;
            if (last_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              last_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              // Flag for the beat that replaces the one just accepted.
              last_q <= (remaining_q == TWO_BEATS);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gray_burst_gen.sv
// gray_burst_gen
// Registered Gray-code burst source. A start pulse in IDLE launches a burst
// of consecutive codes (up or down) over a valid/ready stream, with the
// matching binary count presented alongside. The count persists between
// bursts, so successive bursts continue the sequence.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : burst request, honoured only in IDLE
//   dir         : 1 = count up, 0 = count down (latched at start)
//   load        : preload counter with load_val, honoured only in IDLE
//   load_val    : binary preload value
//   burst_len   : beats per burst, 0 = 2^N (latched at start)
//   out_ready   : consumer accepts the current beat
//   out_valid   : gray_out/bin_out carry a valid beat
//   gray_out    : Gray code of the current count
//   bin_out     : binary count paired with gray_out
//   last        : current beat is the final one of the burst
//   busy        : state is not IDLE
//   done        : one-cycle pulse after the final beat is accepted
module gray_burst_gen
  import gtb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] burst_len,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         last,
  output logic         busy,
  output logic         done
);

  logic         ctrl_idle;
  logic         ctrl_handshake;
  logic         ctrl_dir;

  // The counter doubles as the binary output register: during RUN it always
  // holds the beat on offer, and after a burst it holds the continuation point.
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic [N-1:0] gray_q;
  logic [N-1:0] gray_d;

  gray_burst_ctrl #(
    .N (N)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .dir_i       (dir),
    .burst_len_i (burst_len),
    .out_ready_i (out_ready),
    .idle_o      (ctrl_idle),
    .handshake_o (ctrl_handshake),
    .dir_o       (ctrl_dir),
    .out_valid_o (out_valid),
    .last_o      (last),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Load is only honoured in IDLE; when it coincides with start it still
  // wins, so the first beat of the burst is load_val. Stepping happens only
  // on an accepted beat, which can only occur in RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_idle) begin
      if (load) begin
        cnt_d = load_val;
      end
    end else if (ctrl_handshake) begin
      cnt_d = ctrl_dir ? (cnt_q + N'(1)) : (cnt_q - N'(1));
    end
  end

  // Gray code is derived from the next count so it lands in its register at
  // the same edge as the binary value and is never a stale pairing.
  assign gray_d = N'(bin_to_gray(GTB_FN_W'(cnt_d)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      gray_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  assign bin_out  = cnt_q;
  assign gray_out = gray_q;

endmodule

// File: tb/tb_gray_burst_gen.sv
// Directed bench for gray_burst_gen (N = 8). Each scenario task drives its
// own stimulus and checks outputs 1 time unit after the rising edge.
module tb_gray_burst_gen;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         dir;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] burst_len;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] gray_out;
  logic [N-1:0] bin_out;
  logic         last;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_burst_gen #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .burst_len (burst_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .gray_out  (gray_out),
    .bin_out   (bin_out),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dir = 1'b0; load = 1'b0;
    load_val = '0; burst_len = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, last, busy, done, bin_out, gray_out} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b bin=%h gray=%h want all zero",
               out_valid, last, busy, done, bin_out, gray_out);
    end
    $display("reset: v=%b busy=%b bin=%h gray=%h", out_valid, busy, bin_out, gray_out);
  endtask

  task automatic test_basic_up();
    logic [7:0] eb [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0] eg [4] = '{8'h00, 8'h01, 8'h03, 8'h02};
    load = 1'b1; load_val = 8'h00; start = 1'b1; dir = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic el;
      el = (i == 3);
      total++;
      if ({out_valid, last, bin_out, gray_out} !== {1'b1, el, eb[i], eg[i]}) begin
        bad++;
        $display("FAIL basic_beat%0d: got v=%b l=%b bin=%h gray=%h want v=1 l=%b bin=%h gray=%h",
                 i, out_valid, last, bin_out, gray_out, el, eb[i], eg[i]);
      end
      $display("basic beat %0d: bin=%h gray=%h last=%b", i, bin_out, gray_out, last);
      tick();
    end
    total++;
    if ({done, out_valid, busy} !== 3'b101) begin
      bad++;
      $display("FAIL basic_done: got done=%b v=%b busy=%b want done=1 v=0 busy=1", done, out_valid, busy);
    end
    tick();
    total++;
    if ({done, out_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL basic_idle: got done=%b v=%b busy=%b want 0 0 0", done, out_valid, busy);
    end
    $display("basic burst complete");
  endtask

  task automatic test_wrap_up();
    logic [7:0] eb [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] eg [3] = '{8'h81, 8'h80, 8'h00};
    load = 1'b1; load_val = 8'hFE; start = 1'b1; dir = 1'b1; burst_len = 8'd3; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic el;
      el = (i == 2);
      total++;
      if ({out_valid, last, bin_out, gray_out} !== {1'b1, el, eb[i], eg[i]}) begin
        bad++;
        $display("FAIL wrap_beat%0d: got v=%b l=%b bin=%h gray=%h want v=1 l=%b bin=%h gray=%h",
                 i, out_valid, last, bin_out, gray_out, el, eb[i], eg[i]);
      end
      $display("wrap beat %0d: bin=%h gray=%h last=%b", i, bin_out, gray_out, last);
      tick();
    end
    tick(); // DONE -> IDLE
    start = 1'b1; burst_len = 8'd1;
    tick();
    start = 1'b0;
    total++;
    if ({out_valid, last, bin_out, gray_out} !== {1'b1, 1'b1, 8'h01, 8'h01}) begin
      bad++;
      $display("FAIL wrap_continue: got v=%b l=%b bin=%h gray=%h want v=1 l=1 bin=01 gray=01",
               out_valid, last, bin_out, gray_out);
    end
    $display("continue beat: bin=%h gray=%h last=%b", bin_out, gray_out, last);
    tick();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wrap_len1_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    load = 1'b1; load_val = 8'h00; start = 1'b1; dir = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick(); // beat 1 (00) accepted, beat 2 now presented
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({out_valid, last, bin_out, gray_out} !== {1'b1, 1'b0, 8'h01, 8'h01}) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b l=%b bin=%h gray=%h want v=1 l=0 bin=01 gray=01",
                 k, out_valid, last, bin_out, gray_out);
      end
      $display("stall cycle %0d: bin=%h gray=%h", k, bin_out, gray_out);
      if (k < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, last, gray_out} !== {1'b1, 1'b0, 8'h03}) begin
      bad++;
      $display("FAIL bp_resume3: got v=%b l=%b gray=%h want v=1 l=0 gray=03", out_valid, last, gray_out);
    end
    $display("resume beat: gray=%h", gray_out);
    tick();
    total++;
    if ({out_valid, last, gray_out} !== {1'b1, 1'b1, 8'h02}) begin
      bad++;
      $display("FAIL bp_resume4: got v=%b l=%b gray=%h want v=1 l=1 gray=02", out_valid, last, gray_out);
    end
    $display("resume beat: gray=%h", gray_out);
    tick();
    tick();
  endtask

  task automatic test_down();
    logic [7:0] eb [4] = '{8'h02, 8'h01, 8'h00, 8'hFF};
    logic [7:0] eg [4] = '{8'h03, 8'h01, 8'h00, 8'h80};
    load = 1'b1; load_val = 8'h02; start = 1'b1; dir = 1'b0; burst_len = 8'd4; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic el;
      el = (i == 3);
      total++;
      if ({out_valid, last, bin_out, gray_out} !== {1'b1, el, eb[i], eg[i]}) begin
        bad++;
        $display("FAIL down_beat%0d: got v=%b l=%b bin=%h gray=%h want v=1 l=%b bin=%h gray=%h",
                 i, out_valid, last, bin_out, gray_out, el, eb[i], eg[i]);
      end
      $display("down beat %0d: bin=%h gray=%h last=%b", i, bin_out, gray_out, last);
      tick();
    end
    tick();
  endtask

  task automatic test_full_len();
    logic seen [256];
    logic [7:0] prev;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    prev = 8'h00;
    load = 1'b1; load_val = 8'h00; start = 1'b1; dir = 1'b1; burst_len = 8'd0; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] eb;
      logic [7:0] eg;
      logic el;
      eb = 8'(i);
      eg = eb ^ (eb >> 1);
      el = (i == 255);
      total++;
      if ({out_valid, last, bin_out, gray_out} !== {1'b1, el, eb, eg}) begin
        bad++;
        $display("FAIL full_beat%0d: got v=%b l=%b bin=%h gray=%h want v=1 l=%b bin=%h gray=%h",
                 i, out_valid, last, bin_out, gray_out, el, eb, eg);
      end
      total++;
      if (seen[gray_out] !== 1'b0) begin
        bad++;
        $display("FAIL full_distinct%0d: gray=%h repeated, want unseen code", i, gray_out);
      end
      seen[gray_out] = 1'b1;
      if (i > 0) begin
        total++;
        if ($countones(gray_out ^ prev) != 1) begin
          bad++;
          $display("FAIL full_onebit%0d: got step %h->%h want single-bit change", i, prev, gray_out);
        end
      end
      prev = gray_out;
      $display("full beat %0d: bin=%h gray=%h last=%b", i, bin_out, gray_out, last);
      tick();
    end
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL full_done: got done=%b v=%b want done=1 v=0", done, out_valid);
    end
    tick();
    start = 1'b1; burst_len = 8'd1;
    tick();
    start = 1'b0;
    total++;
    if ({out_valid, bin_out, gray_out} !== {1'b1, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL full_cnt_end: got v=%b bin=%h gray=%h want v=1 bin=00 gray=00",
               out_valid, bin_out, gray_out);
    end
    $display("after full burst: bin=%h", bin_out);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 8'h00; start = 1'b1; dir = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick(); // beat 2 presented
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, last, busy, done, bin_out, gray_out} !== 20'h0) begin
      bad++;
      $display("FAIL midrst_outputs: got v=%b l=%b b=%b d=%b bin=%h gray=%h want all zero",
               out_valid, last, busy, done, bin_out, gray_out);
    end
    $display("mid-burst reset: v=%b busy=%b gray=%h", out_valid, busy, gray_out);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({done, busy, out_valid} !== 3'b000) begin
        bad++;
        $display("FAIL midrst_quiet%0d: got done=%b busy=%b v=%b want 0 0 0", k, done, busy, out_valid);
      end
    end
  endtask

  task automatic test_ignore_in_run();
    // Idle-only load, then a start without load picks up the loaded value.
    load = 1'b1; load_val = 8'h10;
    tick();
    load = 1'b0;
    start = 1'b1; dir = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({out_valid, bin_out} !== {1'b1, 8'h10}) begin
      bad++;
      $display("FAIL run_first: got v=%b bin=%h want v=1 bin=10", out_valid, bin_out);
    end
    // Try to disturb the running burst.
    start = 1'b1; load = 1'b1; load_val = 8'h55; dir = 1'b0; burst_len = 8'd2;
    tick();
    start = 1'b0; load = 1'b0;
    total++;
    if ({out_valid, last, bin_out, gray_out} !== {1'b1, 1'b0, 8'h11, 8'h19}) begin
      bad++;
      $display("FAIL run_ignore2: got v=%b l=%b bin=%h gray=%h want v=1 l=0 bin=11 gray=19",
               out_valid, last, bin_out, gray_out);
    end
    $display("run beat: bin=%h gray=%h", bin_out, gray_out);
    tick();
    total++;
    if ({last, bin_out} !== {1'b0, 8'h12}) begin
      bad++;
      $display("FAIL run_ignore3: got l=%b bin=%h want l=0 bin=12", last, bin_out);
    end
    tick();
    total++;
    if ({last, bin_out, gray_out} !== {1'b1, 8'h13, 8'h1A}) begin
      bad++;
      $display("FAIL run_ignore4: got l=%b bin=%h gray=%h want l=1 bin=13 gray=1A", last, bin_out, gray_out);
    end
    $display("run last beat: bin=%h gray=%h", bin_out, gray_out);
    // Start together with the accepted final beat must be dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL run_last_start_done: got done=%b v=%b want done=1 v=0", done, out_valid);
    end
    tick();
    tick();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL run_last_start_ignored: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap_up();
    test_backpressure();
    test_down();
    test_full_len();
    test_reset_mid();
    test_ignore_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_burst_gen.md
Name: gray_burst_gen

Overview:
- Registered Gray-code sequence source. It sits directly upstream of the gtbtg Gray/binary converter and drives that block's x input.
- On a start pulse it emits a burst of consecutive Gray codes, counting up or down, over a valid/ready stream.
- It also presents the matching binary count so that downstream conversion can be checked in-line.
- The count persists across bursts, so successive bursts continue the sequence.

Parameters:
- N, 8: code width in bits; the counter wraps modulo 2^N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle burst request; honoured only in IDLE.
- dir  input  1  count direction, 1 = up, 0 = down; latched at start.
- load  input  1  preload the counter; honoured only in IDLE.
- load_val  input  N  binary preload value.
- burst_len  input  N  number of beats; 0 means 2^N beats; latched at start.
- out_ready  input  1  consumer accepts the current beat.
- out_valid  output  1  gray_out/bin_out hold a valid beat.
- gray_out  output  N  Gray code of the current count.
- bin_out  output  N  binary count paired with gray_out.
- last  output  1  current beat is the final beat of the burst.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state = IDLE, cnt = 0, remaining = 0, dir_q = 1. All outputs are 0.
- Registers: all outputs are registered; there is no combinational path from any input to any output.
- Gray rule: gray_out = bin_out XOR (bin_out >> 1), always recomputed from the registered count.
- IDLE:
  - out_valid = 0.
  - load = 1 writes cnt <= load_val.
  - start = 1 moves to RUN:
    - latch dir_q <= dir.
    - remaining <= (burst_len == 0) ? 2^N : burst_len. remaining is N+1 bits wide.
    - the first beat is registered at the same edge: bin_out = load ? load_val : cnt.
    - out_valid = 1 on the cycle after start.
  - load and start in the same cycle: load wins for the start value, so the first beat = load_val.
- RUN:
  - out_valid = 1.
  - last = (remaining == 1), registered together with the beat.
  - Handshake = out_valid & out_ready.
  - Without a handshake, all outputs hold stable. Required under backpressure.
  - On a handshake:
    - cnt <= cnt ± 1 mod 2^N, per dir_q.
    - remaining decrements.
    - If the accepted beat had last = 1: go to DONE, out_valid <= 0.
    - Otherwise the next beat appears on the following cycle, giving 1 beat/cycle under continuous ready.
  - start, load, dir and burst_len are ignored; the burst is not restartable.
- DONE: lasts one cycle. done = 1, busy = 1, out_valid = 0, then return to IDLE.
- Continuation: after a burst of L beats from start value c, cnt = c ± L mod 2^N.
- Wrap-around:
  - up: FF -> 00 gives gray 80 -> 00.
  - down: 00 -> FF gives gray 00 -> 80.
  - No special case; every consecutive pair differs in exactly one bit.
- Reset mid-burst: at the next edge, all state and outputs return to their reset values. The partial burst is abandoned and no done pulse is generated.
- Simultaneous out_ready with the final beat and start in the same cycle: start is ignored, because the state is RUN.

Decomposition:
- Package gtb_pkg holds:
  - the state typedef, enum {IDLE, RUN, DONE};
  - the bin_to_gray and gray_to_bin functions, shared with the converter and benches.
- One natural sub-module: gray_burst_ctrl, the FSM plus remaining counter. The datapath (cnt, output registers) stays in the top module.

Test Plan (N = 8):
- rst, load 0x00, start up, len 4, ready = 1 -> gray 00, 01, 03, 02 and bin 00..03 on 4 consecutive cycles; last on beat 4; done pulses the next cycle; busy drops one cycle later.
- load 0xFE, start up, len 3 -> bin FE, FF, 00; gray 81, 80, 00; a follow-up start with len 1 emits bin 01.
- up from 0x00, len 4, drop ready for 3 cycles while beat 2 is presented -> gray_out holds 01 and out_valid stays 1; the sequence resumes 03, 02 with no beat lost.
- load 0x02, start down, len 4 -> bin 02, 01, 00, FF; gray 03, 01, 00, 80.
- len 0 up from 0x00 -> exactly 256 beats; all gray values are distinct with 1-bit steps; last only on beat 256 (gray 80); cnt ends at 00.
- assert rst on beat 2 of a 4-beat burst -> next cycle out_valid = 0, busy = 0, gray_out = 00, done never pulses. Separately, pulse start and load during RUN -> no effect on the sequence.
